// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//
// Accumulates even parity over a frame of 64-bit words and reports, once per
// frame, whether the frame parity matches the parity bit supplied with the
// last word. Frames longer than MAX_LEN words are flagged as overflowed.
// The number of failing frames handed off downstream is kept in a saturating
// counter.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-high reset
//   in_valid   : upstream word valid
//   in_ready   : block accepts a word this cycle (high only while accumulating)
//   in_data    : 64-bit frame word
//   in_last    : current word closes the frame
//   in_par     : expected even-parity bit of the whole frame (last beat only)
//   res_valid  : frame result valid
//   res_ready  : downstream accepts the result
//   res_err    : frame parity check failed
//   res_ovf    : frame exceeded MAX_LEN words
//   res_len    : words counted in the frame, saturating at MAX_LEN
//   err_cnt    : handed-off frames with res_err or res_ovf, saturating
module parity_frame_checker #(
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic        in_par,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_err,
  output logic        res_ovf,
  output logic [7:0]  res_len,
  output logic [15:0] err_cnt
);

  localparam int         DATA_W    = 64;
  localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);

  typedef enum logic {
    ACC,
    REPORT
  } state_t;

  state_t state_q, state_d;

  // Frame accumulators
  logic        acc_par_p0;
  logic [7:0]  wcnt_p0;
  logic        ovf_p0;

  // Registered frame result
  logic        res_err_p1;
  logic        res_ovf_p1;
  logic [7:0]  res_len_p1;

  logic [15:0] err_cnt_q;

  logic        beat;
  logic        res_hs;
  logic        par_nxt;
  logic [7:0]  wcnt_nxt;
  logic        ovf_nxt;

  // Word count saturates at MAX_LEN; further beats only raise overflow.
  function automatic logic [7:0] sat_len_inc(input logic [7:0] v);
    return (v >= MAX_LEN_W) ? MAX_LEN_W : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_cnt_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic word_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  // Next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = REPORT;
      end
      REPORT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  assign beat   = in_valid && in_ready;
  assign res_hs = res_valid && res_ready;

  // Values the accumulators take on a beat; the last beat's result is
  // built from these so it already includes the closing word.
  always_comb begin
    par_nxt  = acc_par_p0 ^ word_parity(in_data);
    wcnt_nxt = sat_len_inc(wcnt_p0);
    ovf_nxt  = ovf_p0 | (wcnt_p0 == MAX_LEN_W);
  end

  // Stage p0: accumulate; stage p1: capture frame result on the last beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACC;
      acc_par_p0 <= 1'b0;
      wcnt_p0    <= 8'd0;
      ovf_p0     <= 1'b0;
      res_err_p1 <= 1'b0;
      res_ovf_p1 <= 1'b0;
      res_len_p1 <= 8'd0;
      err_cnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      if (beat) begin
        acc_par_p0 <= par_nxt;
        wcnt_p0    <= wcnt_nxt;
        ovf_p0     <= ovf_nxt;
        if (in_last) begin
          res_err_p1 <= par_nxt ^ in_par;
          res_ovf_p1 <= ovf_nxt;
          res_len_p1 <= wcnt_nxt;
        end
      end else if (res_hs) begin
        // Result handed off: start the next frame from a clean slate.
        acc_par_p0 <= 1'b0;
        wcnt_p0    <= 8'd0;
        ovf_p0     <= 1'b0;
        if (res_err_p1 || res_ovf_p1) err_cnt_q <= sat_cnt_inc(err_cnt_q);
      end
    end
  end

  assign res_err = res_err_p1;
  assign res_ovf = res_ovf_p1;
  assign res_len = res_len_p1;
  assign err_cnt = err_cnt_q;

endmodule
